branch_ctrl: RTL
================

// Module: branch_ctrl
// PURPOSE
//  Sequences conditional-branch resolution in the EX stage. Accepts one branch op
//  per handshake, decodes funct3, and drives the external signed/unsigned
//  comparator (operands plus unsigned select). It resolves taken/not-taken,
//  computes the target, and issues a redirect to fetch over a valid/ready
//  handshake. It then asserts flush for a fixed number of cycles to kill
//  younger instructions.
// PARAMETERS
//  IDATAW     32  comparator operand width
//  PC_W       32  PC/target width
//  FLUSH_CYC  2   cycles flush is held after redirect accepted (0 = no flush)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  br_valid    in   1       branch op offered
//  br_ready    out  1       block can accept a branch op
//  br_funct3   in   3       RV32I B-type funct3
//  br_pc       in   PC_W    PC of the branch
//  br_imm      in   PC_W    sign-extended byte offset
//  br_rs1      in   IDATAW  operand 1
//  br_rs2      in   IDATAW  operand 2
//  cmp_data1   out  IDATAW  to comparator idata1 (latched rs1)
//  cmp_data2   out  IDATAW  to comparator idata2 (latched rs2)
//  cmp_un      out  1       to comparator unsigned select
//  cmp_eq      in   1       comparator equal
//  cmp_lt      in   1       comparator less-than (per cmp_un)
//  resolved    out  1       1-cycle pulse: outcome valid
//  taken       out  1       outcome of last resolved branch (held)
//  illegal     out  1       1-cycle pulse: funct3 010/011
//  misalign    out  1       1-cycle pulse: taken target[1:0]!=0
//  redir_valid out  1       redirect request to fetch
//  redir_ready in   1       fetch accepts redirect
//  redir_pc    out  PC_W    redirect target
//  flush       out  1       kill younger instructions
// BEHAVIOUR
//  Reset (async): state IDLE. All outputs 0 except br_ready=1. All latches 0.
//  Reset asserted mid-op aborts immediately; redir_valid/flush drop with rst_n.
//  FSM states: IDLE, RESOLVE, REDIRECT, FLUSH. br_ready=1 only in IDLE.
//  IDLE: on br_valid&&br_ready, latch funct3/pc/imm/rs1/rs2 -> RESOLVE.
//  cmp_data1/2 always drive the latched operands; cmp_un = latched funct3[1].
//  RESOLVE (exactly 1 cycle): sample cmp_eq/cmp_lt at the clock edge that leaves RESOLVE.
//   000 BEQ eq | 001 BNE !eq | 100 BLT lt | 101 BGE !lt | 110 BLTU lt | 111 BGEU !lt
//   010/011: illegal pulse, taken=0, no redirect -> IDLE.
//   Target = (pc + imm) mod 2^PC_W, two's-complement wrap, no overflow flag.
//   Not taken: resolved pulse, taken=0 -> IDLE.
//   Taken, target[1:0]!=0: resolved+misalign pulse, taken=1, no redirect -> IDLE.
//   Taken, aligned: resolved pulse, taken=1, redir_pc=target -> REDIRECT.
//  REDIRECT: redir_valid=1; redir_pc stable until redir_ready.
//   Handshake -> FLUSH with count=FLUSH_CYC, or -> IDLE if FLUSH_CYC=0.
//  FLUSH: flush=1 for exactly FLUSH_CYC cycles (counts down to 1), then -> IDLE.
//  Latency: accept at edge E0. Outcome/pulses registered at E1, high in cycle E1..E2.
//  redir_valid first high after E1. br_ready is high again after E1 for a
//   not-taken branch, giving max throughput of 1 branch / 2 cycles.
//  br_valid in a non-IDLE state is ignored and not accepted. Inputs other than
//   cmp_* are don't-care outside IDLE.
// TESTING
//  BEQ rs1=rs2=5, pc=0x100, imm=0x20 -> resolved, taken=1, redir_pc=0x120, flush 2 cyc.
//  BLT rs1=0xFFFFFFFF, rs2=1 -> cmp_un=0, taken=1.
//   BLTU, same operands -> cmp_un=1, taken=0, no redir.
//  Taken BNE with redir_ready low for 5 cycles -> redir_valid/redir_pc stable.
//   br_ready=0 throughout, flush starts after the handshake.
//  pc=0x4, imm=-8, BGE 3>=3 -> redir_pc=0xFFFFFFFC (wrap).
//   pc=0x100, imm=2 taken -> misalign pulse, no redir.
//  funct3=010 -> illegal pulse, taken=0.
//   rst_n low during REDIRECT -> redir_valid=0 async, br_ready=1 after release.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: EX-stage branch resolution sequencer (decode, compare, redirect, flush)
// Ports: br_* op handshake in, cmp_* external comparator, redir_* fetch handshake out, flush out.
module branch_ctrl #(
  parameter int IDATAW    = 32,
  parameter int PC_W      = 32,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_funct3,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [PC_W-1:0]   br_imm,
  input  logic [IDATAW-1:0] br_rs1,
  input  logic [IDATAW-1:0] br_rs2,
  output logic [IDATAW-1:0] cmp_data1,
  output logic [IDATAW-1:0] cmp_data2,
  output logic              cmp_un,
  input  logic              cmp_eq,
  input  logic              cmp_lt,
  output logic              resolved,
  output logic              taken,
  output logic              illegal,
  output logic              misalign,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [PC_W-1:0]   redir_pc,
  output logic              flush
);

  localparam int CNT_W =
    (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESOLVE,
    S_REDIRECT,
    S_FLUSH
  } state_e;

  state_e state_q, state_d;

  logic [2:0]        f3_q, f3_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   imm_q, imm_d;
  logic [IDATAW-1:0] rs1_q, rs1_d;
  logic [IDATAW-1:0] rs2_q, rs2_d;
  logic [PC_W-1:0]   rpc_q, rpc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              res_q, res_d;
  logic              tkn_q, tkn_d;
  logic              ill_q, ill_d;
  logic              mis_q, mis_d;

  logic              accept;
  logic              is_ill;
  logic              cond;
  logic [PC_W-1:0]   target;

  assign accept = (state_q == S_IDLE) && br_valid;
  assign target = pc_q + imm_q;
  assign is_ill = (f3_q[2:1] == 2'b01);

  always_comb begin
    cond = 1'b0;
    unique case (f3_q)
      3'b000:  cond = cmp_eq;
      3'b001:  cond = !cmp_eq;
      3'b100:  cond = cmp_lt;
      3'b101:  cond = !cmp_lt;
      3'b110:  cond = cmp_lt;
      3'b111:  cond = !cmp_lt;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rpc_d   = rpc_q;
    cnt_d   = cnt_q;
    res_d   = 1'b0;
    ill_d   = 1'b0;
    mis_d   = 1'b0;
    tkn_d   = tkn_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d    = br_funct3;
          pc_d    = br_pc;
          imm_d   = br_imm;
          rs1_d   = br_rs1;
          rs2_d   = br_rs2;
          state_d = S_RESOLVE;
        end
      end

      S_RESOLVE: begin
        state_d = S_IDLE;
        if (is_ill) begin
          ill_d = 1'b1;
          tkn_d = 1'b0;
        end else begin
          res_d = 1'b1;
          tkn_d = cond;
          if (cond) begin
            // Misaligned targets are reported, never sent to fetch.
            if (target[1:0] != 2'b00) begin
              mis_d = 1'b1;
            end else begin
              rpc_d   = target;
              state_d = S_REDIRECT;
            end
          end
        end
      end

      S_REDIRECT: begin
        if (redir_ready) begin
          if (FLUSH_CYC == 0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = CNT_W'(FLUSH_CYC);
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rpc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= 1'b0;
      tkn_q   <= 1'b0;
      ill_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rpc_q   <= rpc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      tkn_q   <= tkn_d;
      ill_q   <= ill_d;
      mis_q   <= mis_d;
    end
  end

  assign br_ready    = (state_q == S_IDLE);
  assign redir_valid = (state_q == S_REDIRECT);
  assign flush       = (state_q == S_FLUSH);
  assign cmp_data1   = rs1_q;
  assign cmp_data2   = rs2_q;
  assign cmp_un      = f3_q[1];
  assign redir_pc    = rpc_q;
  assign resolved    = res_q;
  assign taken       = tkn_q;
  assign illegal     = ill_q;
  assign misalign    = mis_q;

endmodule
